// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means accumulator bank: FSM states, channel packing helper
// and default pixel geometry.
package kmeans_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_CH = 3;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIVIDE = 2'd1,
        OUTPUT = 2'd2
    } state_e;

    // Channel 0 sits in the MSBs, so channel idx starts (ch-1-idx) slots above bit 0.
    function automatic int ch_lsb(input int idx, input int ch, input int dw);
        return (ch - 1 - idx) * dw;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one load cycle, then one quotient bit per cycle (AW cycles).
// Only the low QW quotient bits leave the block.
module seq_divider #(
    parameter int AW = 24,
    parameter int CW = 12,
    parameter int QW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          start,
    input  logic [AW-1:0] dividend,
    input  logic [CW-1:0] divisor,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int NW = (AW > 1) ? $clog2(AW) : 1;

    logic [AW-1:0] quo_r;
    logic [CW-1:0] rem_r;
    logic [CW-1:0] dvs_r;
    logic [NW-1:0] cnt_r;
    logic          run_r;
    logic          done_r;
    logic [CW:0]   rem_shift_s;
    logic [CW-1:0] rem_sub_s;
    logic          ge_s;

    // Trial subtraction; the remainder stays below the divisor, so CW bits hold the result.
    always_comb begin
        rem_shift_s = {rem_r, quo_r[AW-1]};
        ge_s        = (rem_shift_s >= {1'b0, dvs_r});
        rem_sub_s   = rem_shift_s[CW-1:0] - dvs_r;
    end

    // Dividend shifts out of quo_r while quotient bits shift in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_r  <= {AW{1'b0}};
            rem_r  <= {CW{1'b0}};
            dvs_r  <= {CW{1'b0}};
            cnt_r  <= {NW{1'b0}};
            run_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (clear) begin
            quo_r  <= {AW{1'b0}};
            rem_r  <= {CW{1'b0}};
            dvs_r  <= {CW{1'b0}};
            cnt_r  <= {NW{1'b0}};
            run_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (run_r) begin
            quo_r  <= {quo_r[AW-2:0], ge_s};
            rem_r  <= ge_s ? rem_sub_s : rem_shift_s[CW-1:0];
            cnt_r  <= cnt_r - 1'b1;
            run_r  <= (cnt_r != {NW{1'b0}});
            done_r <= (cnt_r == {NW{1'b0}});
        end else if (start) begin
            quo_r  <= dividend;
            rem_r  <= {CW{1'b0}};
            dvs_r  <= divisor;
            cnt_r  <= NW'(AW - 1);
            run_r  <= 1'b1;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done     = done_r;
    assign quotient = quo_r[QW-1:0];

endmodule

// File: rtl/cluster_accum_bank.sv
// K-way k-means accumulator bank: per-cluster channel sums and pixel counts, then a
// sequential divide pass that streams one mean per cluster through a shared divider.
module cluster_accum_bank
    import kmeans_pkg::*;
#(
    parameter int K  = 4,
    parameter int CH = DEF_CH,
    parameter int DW = DEF_DW,
    parameter int CW = 12,
    parameter int AW = 24,
    parameter int KW = $clog2(K)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [CH*DW-1:0] pix_data,
    input  logic [KW-1:0]    pix_cluster,
    input  logic             finish,
    output logic             mean_valid,
    output logic [KW-1:0]    mean_cluster,
    output logic [CH*DW-1:0] mean_data,
    output logic             mean_empty,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    if (AW < DW + CW) begin : g_bad_aw
        $error("cluster_accum_bank: AW must be at least DW+CW");
    end
    if (K < 2) begin : g_bad_k
        $error("cluster_accum_bank: K must be at least 2");
    end

    state_e           state_r, state_n;
    logic [AW-1:0]    acc_r [K][CH];
    logic [CW-1:0]    cnt_r [K];
    logic [KW-1:0]    clu_r;
    logic [CHW-1:0]   ch_r;
    logic             seq_r;
    logic [CH*DW-1:0] buf_r, buf_n_s;

    logic             xfer_s, idx_ok_s, sat_s, drop_s, flush_s;
    logic             empty_s, last_clu_s, div_last_s;
    logic             start_s, div_done_s;
    logic [CHW-1:0]   div_ch_s;
    logic [DW-1:0]    quotient_s;

    logic             pix_ready_r, pix_ready_n;
    logic             mean_valid_r, mean_valid_n;
    logic [KW-1:0]    mean_cluster_r, mean_cluster_n;
    logic [CH*DW-1:0] mean_data_r, mean_data_n;
    logic             mean_empty_r, mean_empty_n;
    logic             busy_r, busy_n;
    logic             done_r, done_n;
    logic             overflow_r, overflow_n;

    // A power-of-two K makes every index legal; otherwise indices >= K are discarded.
    if ((1 << KW) == K) begin : g_idx_full
        assign idx_ok_s = 1'b1;
    end else begin : g_idx_cmp
        assign idx_ok_s = (pix_cluster < KW'(K));
    end

    assign xfer_s     = pix_valid && pix_ready_r;
    assign sat_s      = idx_ok_s && (cnt_r[pix_cluster] == {CW{1'b1}});
    assign drop_s     = xfer_s && sat_s;
    assign flush_s    = (state_r == OUTPUT) && last_clu_s;
    assign empty_s    = (cnt_r[clu_r] == {CW{1'b0}});
    assign last_clu_s = (clu_r == KW'(K - 1));
    assign div_last_s = (ch_r == CHW'(CH - 1));

    // Next channel starts in the same cycle the previous quotient arrives.
    assign start_s  = (state_r == DIVIDE) && !empty_s &&
                      (!seq_r || (div_done_s && !div_last_s));
    assign div_ch_s = div_done_s ? (ch_r + 1'b1) : ch_r;

    seq_divider #(
        .AW(AW),
        .CW(CW),
        .QW(DW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .start    (start_s),
        .dividend (acc_r[clu_r][div_ch_s]),
        .divisor  (cnt_r[clu_r]),
        .done     (div_done_s),
        .quotient (quotient_s)
    );

    // Per-cluster sums and counts; a saturated counter freezes its cluster.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < K; k++) begin
                cnt_r[k] <= {CW{1'b0}};
                for (int c = 0; c < CH; c++) acc_r[k][c] <= {AW{1'b0}};
            end
        end else if (clear || flush_s) begin
            for (int k = 0; k < K; k++) begin
                cnt_r[k] <= {CW{1'b0}};
                for (int c = 0; c < CH; c++) acc_r[k][c] <= {AW{1'b0}};
            end
        end else if (xfer_s && idx_ok_s && !sat_s) begin
            cnt_r[pix_cluster] <= cnt_r[pix_cluster] + 1'b1;
            for (int c = 0; c < CH; c++) begin
                acc_r[pix_cluster][c] <= acc_r[pix_cluster][c] +
                    {{(AW-DW){1'b0}}, pix_data[ch_lsb(c, CH, DW) +: DW]};
            end
        end
    end

    // Collects each channel quotient into its packed slot as it completes.
    always_comb begin
        buf_n_s = buf_r;
        if (div_done_s) begin
            buf_n_s[ch_lsb(int'(ch_r), CH, DW) +: DW] = quotient_s;
        end else begin
            buf_n_s = buf_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ACCUM;
        end else if (clear) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic; finish is only honoured while accumulating.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ACCUM:   state_n = finish ? DIVIDE : ACCUM;
            DIVIDE: begin
                if (empty_s || (div_done_s && div_last_s)) state_n = OUTPUT;
                else                                      state_n = DIVIDE;
            end
            OUTPUT:  state_n = last_clu_s ? ACCUM : DIVIDE;
            default: state_n = ACCUM;
        endcase
    end

    // Cluster/channel sequencing for the divide pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clu_r <= {KW{1'b0}};
            ch_r  <= {CHW{1'b0}};
            seq_r <= 1'b0;
            buf_r <= {(CH*DW){1'b0}};
        end else if (clear) begin
            clu_r <= {KW{1'b0}};
            ch_r  <= {CHW{1'b0}};
            seq_r <= 1'b0;
            buf_r <= {(CH*DW){1'b0}};
        end else begin
            buf_r <= buf_n_s;
            case (state_r)
                DIVIDE: begin
                    seq_r <= seq_r | start_s;
                    if (div_done_s) ch_r <= ch_r + 1'b1;
                end
                OUTPUT: begin
                    clu_r <= clu_r + 1'b1;
                    ch_r  <= {CHW{1'b0}};
                    seq_r <= 1'b0;
                end
                default: begin
                    clu_r <= {KW{1'b0}};
                    ch_r  <= {CHW{1'b0}};
                    seq_r <= 1'b0;
                end
            endcase
        end
    end

    // Next values of the registered outputs; results hold until the next one.
    always_comb begin
        mean_valid_n = (state_r == DIVIDE) && (state_n == OUTPUT);
        done_n       = mean_valid_n && last_clu_s;
        busy_n       = (state_n != ACCUM);
        pix_ready_n  = (state_n == ACCUM);
        overflow_n   = overflow_r | drop_s;
        if (mean_valid_n) begin
            mean_cluster_n = clu_r;
            mean_empty_n   = empty_s;
            mean_data_n    = empty_s ? {(CH*DW){1'b0}} : buf_n_s;
        end else begin
            mean_cluster_n = mean_cluster_r;
            mean_empty_n   = mean_empty_r;
            mean_data_n    = mean_data_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_ready_r    <= 1'b1;
            mean_valid_r   <= 1'b0;
            mean_cluster_r <= {KW{1'b0}};
            mean_data_r    <= {(CH*DW){1'b0}};
            mean_empty_r   <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            overflow_r     <= 1'b0;
        end else if (clear) begin
            pix_ready_r    <= 1'b1;
            mean_valid_r   <= 1'b0;
            mean_cluster_r <= {KW{1'b0}};
            mean_data_r    <= {(CH*DW){1'b0}};
            mean_empty_r   <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            overflow_r     <= 1'b0;
        end else begin
            pix_ready_r    <= pix_ready_n;
            mean_valid_r   <= mean_valid_n;
            mean_cluster_r <= mean_cluster_n;
            mean_data_r    <= mean_data_n;
            mean_empty_r   <= mean_empty_n;
            busy_r         <= busy_n;
            done_r         <= done_n;
            overflow_r     <= overflow_n;
        end
    end

    assign pix_ready    = pix_ready_r;
    assign mean_valid   = mean_valid_r;
    assign mean_cluster = mean_cluster_r;
    assign mean_data    = mean_data_r;
    assign mean_empty   = mean_empty_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign overflow     = overflow_r;

endmodule
